scoreboard_issue: RTL and testbench

SCOREBOARD_ISSUE -- requirements
Module: scoreboard_issue

---
 rtl/scoreboard_issue.sv | 127 ++++++++++++
 tb/tb_scoreboard_issue.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_issue.sv
// In-order issue/retire scoreboard: allocates entries at the tail, marks them done
// on completion, retires them from the head, and drives one registered write per cycle.
module scoreboard_issue #(
  parameter  int SCRBRD_SIZE  = 32,
  parameter  int PC_WIDTH     = 32,
  parameter  int OPCODE_WIDTH = 5,
  localparam int IDX_W        = $clog2(SCRBRD_SIZE),
  localparam int CNT_W        = IDX_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_vld,
  output logic                    issue_rdy,
  input  logic [PC_WIDTH-1:0]     issue_pc,
  input  logic [OPCODE_WIDTH-1:0] issue_opcode,
  output logic [IDX_W-1:0]        issue_idx,
  input  logic                    cmpl_vld,
  output logic                    cmpl_rdy,
  input  logic [IDX_W-1:0]        cmpl_idx,
  input  logic                    flush,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_pc_vld,
  output logic [PC_WIDTH-1:0]     out_pc,
  output logic                    out_opcode_vld,
  output logic [OPCODE_WIDTH-1:0] out_opcode,
  output logic                    out_completed_vld,
  output logic                    out_invalidate_vld,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty,
  output logic                    cmpl_err
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   head, tail;
  logic [SCRBRD_SIZE-1:0] done;

  logic             idle, flush_take, retire, pop;
  logic             cmpl_take, cmpl_live, issue_take;
  logic [IDX_W-1:0] cmpl_off;

  // Decision logic for this cycle: flush > retire > completion > issue.
  assign idle       = (state == S_IDLE);
  assign full       = (count == CNT_W'(SCRBRD_SIZE));
  assign empty      = (count == '0);
  assign issue_idx  = tail;
  assign flush_take = idle && flush && !empty;
  assign retire     = idle && !flush_take && !empty && done[head];
  assign pop        = retire || (state == S_FLUSH);

  assign cmpl_rdy   = idle && !retire && !flush_take;
  assign cmpl_take  = cmpl_vld && cmpl_rdy;
  // Live entries occupy [head, head+count) modulo the ring size.
  assign cmpl_off   = cmpl_idx - head;
  assign cmpl_live  = ({1'b0, cmpl_off} < count);

  assign issue_rdy  = idle && !full && !retire && !cmpl_take && !flush_take;
  assign issue_take = issue_vld && issue_rdy;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (flush_take) state_nxt = S_FLUSH;
      S_FLUSH: if (count == CNT_W'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: the done bits are control state, not storage, so they are reset along with the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      done               <= '0;
      out_idx            <= '0;
      out_pc_vld         <= 1'b0;
      out_pc             <= '0;
      out_opcode_vld     <= 1'b0;
      out_opcode         <= '0;
      out_completed_vld  <= 1'b0;
      out_invalidate_vld <= 1'b0;
      cmpl_err           <= 1'b0;
    end else begin
      out_pc_vld         <= 1'b0;
      out_opcode_vld     <= 1'b0;
      out_completed_vld  <= 1'b0;
      out_invalidate_vld <= 1'b0;
      cmpl_err           <= 1'b0;

      if (pop) begin
        out_invalidate_vld <= 1'b1;
        out_idx            <= head;
        done[head]         <= 1'b0;
        head               <= head + 1'b1;
        count              <= count - 1'b1;
      end else if (cmpl_take) begin
        if (cmpl_live) begin
          done[cmpl_idx]    <= 1'b1;
          out_completed_vld <= 1'b1;
          out_idx           <= cmpl_idx;
        end else begin
          cmpl_err <= 1'b1;
        end
      end else if (issue_take) begin
        out_pc_vld     <= 1'b1;
        out_opcode_vld <= 1'b1;
        out_idx        <= tail;
        out_pc         <= issue_pc;
        out_opcode     <= issue_opcode;
        done[tail]     <= 1'b0;
        tail           <= tail + 1'b1;
        count          <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_issue.sv
// Bench for scoreboard_issue: expected scoreboard writes are queued as stimulus is
// driven and popped by a monitor whenever the DUT produces a write.
module tb_scoreboard_issue;

  localparam int SIZE = 32;
  localparam int PCW  = 32;
  localparam int OPW  = 5;
  localparam int IW   = $clog2(SIZE);
  localparam int CW   = IW + 1;

  logic           clk, rst;
  logic           issue_vld, issue_rdy;
  logic [PCW-1:0] issue_pc;
  logic [OPW-1:0] issue_opcode;
  logic [IW-1:0]  issue_idx;
  logic           cmpl_vld, cmpl_rdy;
  logic [IW-1:0]  cmpl_idx;
  logic           flush;
  logic [IW-1:0]  out_idx;
  logic           out_pc_vld, out_opcode_vld, out_completed_vld, out_invalidate_vld;
  logic [PCW-1:0] out_pc;
  logic [OPW-1:0] out_opcode;
  logic [CW-1:0]  count;
  logic           full, empty, cmpl_err;

  scoreboard_issue #(.SCRBRD_SIZE(SIZE), .PC_WIDTH(PCW), .OPCODE_WIDTH(OPW)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy),
    .issue_pc(issue_pc), .issue_opcode(issue_opcode), .issue_idx(issue_idx),
    .cmpl_vld(cmpl_vld), .cmpl_rdy(cmpl_rdy), .cmpl_idx(cmpl_idx),
    .flush(flush),
    .out_idx(out_idx), .out_pc_vld(out_pc_vld), .out_pc(out_pc),
    .out_opcode_vld(out_opcode_vld), .out_opcode(out_opcode),
    .out_completed_vld(out_completed_vld), .out_invalidate_vld(out_invalidate_vld),
    .count(count), .full(full), .empty(empty), .cmpl_err(cmpl_err)
  );

  typedef enum logic [1:0] {W_ISSUE, W_CMPL, W_INV} wkind_t;
  typedef struct {
    wkind_t         kind;
    logic [IW-1:0]  idx;
    logic [PCW-1:0] pc;
    logic [OPW-1:0] op;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass   = 0;
  int   n_checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

  function automatic void push_exp(wkind_t k, int idx, logic [PCW-1:0] pc, logic [OPW-1:0] op);
    exp_t e;
    e.kind = k;
    e.idx  = IW'(idx);
    e.pc   = pc;
    e.op   = op;
    exp_q.push_back(e);
  endfunction

  // Write monitor: every registered write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && (out_pc_vld || out_opcode_vld || out_completed_vld || out_invalidate_vld)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got vld(pc,op,cmpl,inv)=%b%b%b%b idx=%0d, required no write",
                 out_pc_vld, out_opcode_vld, out_completed_vld, out_invalidate_vld, out_idx);
      end else begin
        logic [3:0] vexp;
        logic       ok;
        mon_e = exp_q.pop_front();
        case (mon_e.kind)
          W_ISSUE: vexp = 4'b1100;
          W_CMPL:  vexp = 4'b0010;
          default: vexp = 4'b0001;
        endcase
        ok = ({out_pc_vld, out_opcode_vld, out_completed_vld, out_invalidate_vld} === vexp)
             && (out_idx === mon_e.idx);
        if (mon_e.kind == W_ISSUE)
          ok = ok && (out_pc === mon_e.pc) && (out_opcode === mon_e.op);
        if (!ok)
          $display("FAIL write_%s: got vld=%b idx=%0d pc=%h op=%0d, required vld=%b idx=%0d pc=%h op=%0d",
                   mon_e.kind.name(),
                   {out_pc_vld, out_opcode_vld, out_completed_vld, out_invalidate_vld},
                   out_idx, out_pc, out_opcode, vexp, mon_e.idx, mon_e.pc, mon_e.op);
        else
          n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    issue_vld = 1'b0; cmpl_vld = 1'b0; flush = 1'b0;
    issue_pc = '0; issue_opcode = '0; cmpl_idx = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drive_issue(logic [PCW-1:0] pc, logic [OPW-1:0] op);
    issue_vld = 1'b1; issue_pc = pc; issue_opcode = op;
    step();
    issue_vld = 1'b0;
  endtask

  task automatic drive_cmpl(int idx);
    cmpl_vld = 1'b1; cmpl_idx = IW'(idx);
    step();
    cmpl_vld = 1'b0;
  endtask

  task automatic wait_drain(string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL %s_drain: %0d expected writes never seen, required 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    issue_vld = 1'b0; cmpl_vld = 1'b0; flush = 1'b0;
    issue_pc = '0; issue_opcode = '0; cmpl_idx = '0;
    #2;
    n_checks++;
    if ({out_pc_vld, out_opcode_vld, out_completed_vld, out_invalidate_vld, cmpl_err} !== 5'b0)
      $display("FAIL reset_vld: got %b, required 00000",
               {out_pc_vld, out_opcode_vld, out_completed_vld, out_invalidate_vld, cmpl_err});
    else n_pass++;
    n_checks++;
    if (count !== CW'(0) || out_idx !== IW'(0) || out_pc !== '0 || out_opcode !== '0)
      $display("FAIL reset_regs: got count=%0d idx=%0d pc=%h op=%0d, required all 0",
               count, out_idx, out_pc, out_opcode);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({empty, full, issue_rdy, cmpl_rdy} !== 4'b1011 || issue_idx !== IW'(0))
      $display("FAIL reset_status: got empty/full/irdy/crdy=%b issue_idx=%0d, required 1011 idx 0",
               {empty, full, issue_rdy, cmpl_rdy}, issue_idx);
    else n_pass++;
  endtask

  task automatic test_single_issue();
    apply_reset();
    push_exp(W_ISSUE, 0, 32'h100, 5'd3);
    drive_issue(32'h100, 5'd3);
    n_checks++;
    if (count !== CW'(1) || issue_idx !== IW'(1) || empty !== 1'b0)
      $display("FAIL single_count: got count=%0d issue_idx=%0d empty=%b, required 1 1 0",
               count, issue_idx, empty);
    else n_pass++;
    push_exp(W_CMPL, 0, '0, '0);
    push_exp(W_INV, 0, '0, '0);
    drive_cmpl(0);
    n_checks++;
    if (cmpl_rdy !== 1'b0 || issue_rdy !== 1'b0)
      $display("FAIL single_retire_rdy: got cmpl_rdy=%b issue_rdy=%b, required 0 0", cmpl_rdy, issue_rdy);
    else n_pass++;
    step();
    n_checks++;
    if (count !== CW'(0) || empty !== 1'b1)
      $display("FAIL single_retired: got count=%0d empty=%b, required 0 1", count, empty);
    else n_pass++;
    step();
    n_checks++;
    if (out_invalidate_vld !== 1'b0 || out_idx !== IW'(0) || out_pc !== 32'h100 || out_opcode !== 5'd3)
      $display("FAIL single_hold: got inv=%b idx=%0d pc=%h op=%0d, required 0 0 100 3",
               out_invalidate_vld, out_idx, out_pc, out_opcode);
    else n_pass++;
    wait_drain("single");
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < SIZE; i++) begin
      push_exp(W_ISSUE, i, 32'h1000 + 32'(i) * 4, OPW'(i));
      drive_issue(32'h1000 + 32'(i) * 4, OPW'(i));
    end
    n_checks++;
    if (full !== 1'b1 || issue_rdy !== 1'b0 || count !== CW'(SIZE))
      $display("FAIL full_status: got full=%b issue_rdy=%b count=%0d, required 1 0 %0d",
               full, issue_rdy, count, SIZE);
    else n_pass++;
    drive_issue(32'hdead, 5'd9);
    n_checks++;
    if (count !== CW'(SIZE))
      $display("FAIL full_reject: got count=%0d, required %0d", count, SIZE);
    else n_pass++;
    push_exp(W_CMPL, 0, '0, '0);
    push_exp(W_INV, 0, '0, '0);
    drive_cmpl(0);
    step();
    n_checks++;
    if (count !== CW'(SIZE - 1) || issue_rdy !== 1'b1 || issue_idx !== IW'(0) || full !== 1'b0)
      $display("FAIL full_after_retire: got count=%0d issue_rdy=%b issue_idx=%0d full=%b, required 31 1 0 0",
               count, issue_rdy, issue_idx, full);
    else n_pass++;
    push_exp(W_ISSUE, 0, 32'h2000, 5'd7);
    drive_issue(32'h2000, 5'd7);
    n_checks++;
    if (count !== CW'(SIZE) || full !== 1'b1 || issue_idx !== IW'(1))
      $display("FAIL full_wrap: got count=%0d full=%b issue_idx=%0d, required 32 1 1", count, full, issue_idx);
    else n_pass++;
    wait_drain("full");
  endtask

  task automatic test_out_of_order();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(W_ISSUE, i, 32'h40 + 32'(i), OPW'(i + 1));
      drive_issue(32'h40 + 32'(i), OPW'(i + 1));
    end
    push_exp(W_CMPL, 2, '0, '0);
    drive_cmpl(2);
    step();
    push_exp(W_CMPL, 1, '0, '0);
    drive_cmpl(1);
    repeat (3) step();
    n_checks++;
    if (count !== CW'(3))
      $display("FAIL ooo_no_retire: got count=%0d, required 3", count);
    else n_pass++;
    push_exp(W_CMPL, 0, '0, '0);
    push_exp(W_INV, 0, '0, '0);
    push_exp(W_INV, 1, '0, '0);
    push_exp(W_INV, 2, '0, '0);
    drive_cmpl(0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (count !== CW'(2 - k) || out_invalidate_vld !== 1'b1 || out_idx !== IW'(k))
        $display("FAIL ooo_retire_%0d: got count=%0d inv=%b idx=%0d, required %0d 1 %0d",
                 k, count, out_invalidate_vld, out_idx, 2 - k, k);
      else n_pass++;
    end
    wait_drain("ooo");
  endtask

  task automatic test_priority();
    apply_reset();
    push_exp(W_ISSUE, 0, 32'h500, 5'd2);
    drive_issue(32'h500, 5'd2);
    issue_vld = 1'b1; issue_pc = 32'h600; issue_opcode = 5'd4;
    cmpl_vld = 1'b1; cmpl_idx = '0;
    #1;
    n_checks++;
    if (issue_rdy !== 1'b0 || cmpl_rdy !== 1'b1)
      $display("FAIL prio_cmpl_over_issue: got issue_rdy=%b cmpl_rdy=%b, required 0 1", issue_rdy, cmpl_rdy);
    else n_pass++;
    push_exp(W_CMPL, 0, '0, '0);
    step();
    cmpl_vld = 1'b0;
    #1;
    n_checks++;
    if (issue_rdy !== 1'b0 || cmpl_rdy !== 1'b0)
      $display("FAIL prio_retire_first: got issue_rdy=%b cmpl_rdy=%b, required 0 0", issue_rdy, cmpl_rdy);
    else n_pass++;
    push_exp(W_INV, 0, '0, '0);
    step();
    push_exp(W_ISSUE, 1, 32'h600, 5'd4);
    step();
    issue_vld = 1'b0;
    n_checks++;
    if (count !== CW'(1) || issue_idx !== IW'(2))
      $display("FAIL prio_late_issue: got count=%0d issue_idx=%0d, required 1 2", count, issue_idx);
    else n_pass++;
    wait_drain("prio");
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_exp(W_ISSUE, i, 32'h80 + 32'(i), OPW'(i));
      drive_issue(32'h80 + 32'(i), OPW'(i));
    end
    flush = 1'b1; cmpl_vld = 1'b1; cmpl_idx = '0;
    issue_vld = 1'b1; issue_pc = 32'hbad; issue_opcode = 5'd1;
    #1;
    n_checks++;
    if (issue_rdy !== 1'b0 || cmpl_rdy !== 1'b0)
      $display("FAIL flush_blocks: got issue_rdy=%b cmpl_rdy=%b, required 0 0", issue_rdy, cmpl_rdy);
    else n_pass++;
    for (int i = 0; i < 4; i++) push_exp(W_INV, i, '0, '0);
    step();
    flush = 1'b0; cmpl_vld = 1'b0; issue_vld = 1'b0;
    n_checks++;
    if (count !== CW'(4) || issue_rdy !== 1'b0)
      $display("FAIL flush_enter: got count=%0d issue_rdy=%b, required 4 0", count, issue_rdy);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      flush = (k == 1);
      step();
      n_checks++;
      if (count !== CW'(3 - k))
        $display("FAIL flush_step_%0d: got count=%0d, required %0d", k, count, 3 - k);
      else n_pass++;
    end
    flush = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || issue_rdy !== 1'b1 || cmpl_rdy !== 1'b1)
      $display("FAIL flush_done: got empty=%b issue_rdy=%b cmpl_rdy=%b, required 1 1 1",
               empty, issue_rdy, cmpl_rdy);
    else n_pass++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    n_checks++;
    if (issue_rdy !== 1'b1 || empty !== 1'b1)
      $display("FAIL flush_empty_noop: got issue_rdy=%b empty=%b, required 1 1", issue_rdy, empty);
    else n_pass++;
    wait_drain("flush");
  endtask

  task automatic test_cmpl_err();
    apply_reset();
    push_exp(W_ISSUE, 0, 32'h10, 5'd1);
    drive_issue(32'h10, 5'd1);
    push_exp(W_ISSUE, 1, 32'h14, 5'd2);
    drive_issue(32'h14, 5'd2);
    drive_cmpl(5);
    n_checks++;
    if (cmpl_err !== 1'b1 || out_completed_vld !== 1'b0 || out_invalidate_vld !== 1'b0)
      $display("FAIL err_pulse: got cmpl_err=%b cmpl=%b inv=%b, required 1 0 0",
               cmpl_err, out_completed_vld, out_invalidate_vld);
    else n_pass++;
    step();
    n_checks++;
    if (cmpl_err !== 1'b0 || count !== CW'(2))
      $display("FAIL err_clear: got cmpl_err=%b count=%0d, required 0 2", cmpl_err, count);
    else n_pass++;
    wait_drain("err");
  endtask

  task automatic test_reset_mid_flush();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_exp(W_ISSUE, i, 32'hc0 + 32'(i), OPW'(i));
      drive_issue(32'hc0 + 32'(i), OPW'(i));
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    push_exp(W_INV, 0, '0, '0);
    step();
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_invalidate_vld !== 1'b0 || count !== CW'(0) || out_idx !== IW'(0) || out_pc !== '0)
      $display("FAIL rst_flush_clear: got inv=%b count=%0d idx=%0d pc=%h, required 0 0 0 0",
               out_invalidate_vld, count, out_idx, out_pc);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (issue_rdy !== 1'b1 || cmpl_rdy !== 1'b1 || empty !== 1'b1 || issue_idx !== IW'(0))
      $display("FAIL rst_flush_release: got issue_rdy=%b cmpl_rdy=%b empty=%b issue_idx=%0d, required 1 1 1 0",
               issue_rdy, cmpl_rdy, empty, issue_idx);
    else n_pass++;
    push_exp(W_ISSUE, 0, 32'h300, 5'd1);
    drive_issue(32'h300, 5'd1);
    wait_drain("rst_flush");
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_full_wrap();
    test_out_of_order();
    test_priority();
    test_flush();
    test_cmpl_err();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
